core_bus_demux: RTL and testbench

CORE_BUS_DEMUX -- requirements
Module: core_bus_demux

---
 rtl/core_bus_demux.sv | 148 ++++++++++++++
 tb/tb_core_bus_demux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/core_bus_demux.sv
// core_bus_demux: address-decoding bridge from one core memory port to N_SLV slave ports
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb  core request (wstrb==0 is a read)
//   mem_ready, mem_rdata        one-cycle completion pulse and read data to the core
//   slv_valid                   one-hot request to the decoded slave
//   slv_instr/addr/wdata/wstrb  registered request broadcast to all slaves
//   slv_ready, slv_rdata        per-slave completion and packed read data
//   bus_err                     error pulse, coincident with mem_ready
//   err_addr, err_cnt           address of the last error, saturating error count
module core_bus_demux #(
  parameter int                   N_SLV     = 2,
  parameter logic [N_SLV*32-1:0]  ADDR_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0]  ADDR_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                   TIMEOUT   = 256,
  parameter logic [31:0]          ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [N_SLV-1:0]      slv_valid,
  output logic                  slv_instr,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_wstrb,
  input  logic [N_SLV-1:0]      slv_ready,
  input  logic [N_SLV*32-1:0]   slv_rdata,
  output logic                  bus_err,
  output logic [31:0]           err_addr,
  output logic [15:0]           err_cnt
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;
  state_t state_q, state_d;
  logic mem_ready_q, mem_ready_d, slv_instr_q, slv_instr_d, bus_err_q, bus_err_d;
  logic [31:0] mem_rdata_q, mem_rdata_d, slv_addr_q, slv_addr_d, slv_wdata_q, slv_wdata_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [N_SLV-1:0] slv_valid_q, slv_valid_d, hit;
  logic [3:0] slv_wstrb_q, slv_wstrb_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel_rdy;
  logic [31:0] sel_rdata;
  // Descending scan so the lowest matching slave index is the one left in hit.
  // slv_valid_q doubles as the registered one-hot select while in ACCESS.
  always_comb begin
    hit = '0;
    sel_rdata = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((mem_addr & ADDR_MASK[32*i+:32]) == (ADDR_BASE[32*i+:32] & ADDR_MASK[32*i+:32]))
        hit = N_SLV'(1) << i;
    for (int i = 0; i < N_SLV; i++)
      sel_rdata = sel_rdata | (slv_rdata[32*i+:32] & {32{slv_valid_q[i]}});
    sel_rdy = |(slv_ready & slv_valid_q);
  end
  always_comb begin
    state_d = state_q;
    mem_ready_d = 1'b0;
    bus_err_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    slv_valid_d = slv_valid_q;
    slv_instr_d = slv_instr_q;
    slv_addr_d = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    slv_wstrb_d = slv_wstrb_q;
    err_addr_d = err_addr_q;
    err_cnt_d = err_cnt_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (mem_valid) begin
        slv_addr_d = mem_addr;
        slv_wdata_d = mem_wdata;
        slv_wstrb_d = mem_wstrb;
        slv_instr_d = mem_instr;
        slv_valid_d = hit;
        cnt_d = '0;
        state_d = |hit ? ACCESS : ERROR;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready is tested before the timeout so a last-cycle completion wins.
        if (sel_rdy) begin
          mem_rdata_d = sel_rdata;
          mem_ready_d = 1'b1;
          slv_valid_d = '0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          slv_valid_d = '0;
          state_d = ERROR;
        end
      end
      ERROR: begin
        mem_rdata_d = ERR_RDATA;
        mem_ready_d = 1'b1;
        bus_err_d = 1'b1;
        err_addr_d = slv_addr_q;
        err_cnt_d = err_cnt_q == 16'hFFFF ? err_cnt_q : err_cnt_q + 16'd1;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      slv_valid_q <= '0;
      slv_instr_q <= 1'b0;
      slv_addr_q <= '0;
      slv_wdata_q <= '0;
      slv_wstrb_q <= '0;
      bus_err_q <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      slv_valid_q <= slv_valid_d;
      slv_instr_q <= slv_instr_d;
      slv_addr_q <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      slv_wstrb_q <= slv_wstrb_d;
      bus_err_q <= bus_err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q <= err_cnt_d;
      cnt_q <= cnt_d;
    end
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign slv_valid = slv_valid_q;
  assign slv_instr = slv_instr_q;
  assign slv_addr = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign slv_wstrb = slv_wstrb_q;
  assign bus_err = bus_err_q;
  assign err_addr = err_addr_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_core_bus_demux.sv
// tb_core_bus_demux: table-driven bench for core_bus_demux (default and TIMEOUT=4 instances)
module tb_core_bus_demux;
  logic clk, reset, mem_valid_a, mem_valid_t, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [1:0] slv_ready_a, slv_ready_t;
  logic [63:0] slv_rdata;
  logic mem_ready, slv_instr, bus_err, mem_ready_t, slv_instr_t, bus_err_t;
  logic [31:0] mem_rdata, slv_addr, slv_wdata, err_addr, mem_rdata_t, slv_addr_t, slv_wdata_t, err_addr_t;
  logic [1:0] slv_valid, slv_valid_t;
  logic [3:0] slv_wstrb, slv_wstrb_t;
  logic [15:0] err_cnt, err_cnt_t;
  int total = 0, bad = 0;
  bit tsel = 0;
  logic m_ready, m_err, m_sinstr;
  logic [31:0] m_rdata, m_eaddr, m_saddr, m_swdata;
  logic [15:0] m_ecnt;
  logic [1:0] m_sv;
  logic [3:0] m_swstrb;
  assign m_ready = tsel ? mem_ready_t : mem_ready;
  assign m_err = tsel ? bus_err_t : bus_err;
  assign m_sinstr = tsel ? slv_instr_t : slv_instr;
  assign m_rdata = tsel ? mem_rdata_t : mem_rdata;
  assign m_eaddr = tsel ? err_addr_t : err_addr;
  assign m_saddr = tsel ? slv_addr_t : slv_addr;
  assign m_swdata = tsel ? slv_wdata_t : slv_wdata;
  assign m_ecnt = tsel ? err_cnt_t : err_cnt;
  assign m_sv = tsel ? slv_valid_t : slv_valid;
  assign m_swstrb = tsel ? slv_wstrb_t : slv_wstrb;
  core_bus_demux u_dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid_a), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .slv_valid(slv_valid),
    .slv_instr(slv_instr), .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_ready(slv_ready_a), .slv_rdata(slv_rdata), .bus_err(bus_err),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );
  core_bus_demux #(.TIMEOUT(4)) u_to (
    .clk(clk), .reset(reset), .mem_valid(mem_valid_t), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready_t), .mem_rdata(mem_rdata_t), .slv_valid(slv_valid_t),
    .slv_instr(slv_instr_t), .slv_addr(slv_addr_t), .slv_wdata(slv_wdata_t), .slv_wstrb(slv_wstrb_t),
    .slv_ready(slv_ready_t), .slv_rdata(slv_rdata), .bus_err(bus_err_t),
    .err_addr(err_addr_t), .err_cnt(err_cnt_t)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  typedef struct {
    bit to;
    logic [31:0] addr, wdata;
    logic [3:0] wstrb;
    logic instr;
    int wt;
    logic [31:0] rd0, rd1;
    logic [1:0] sel;
    logic [31:0] rdata;
    logic err;
    int lat, nacc;
    logic [15:0] ecnt;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "_ctl"}, {mem_ready, bus_err, slv_valid, slv_instr, slv_wstrb}, 0);
    chk({nm, "_rdata"}, mem_rdata, 0);
    chk({nm, "_saddr"}, slv_addr, 0);
    chk({nm, "_swdata"}, slv_wdata, 0);
    chk({nm, "_eaddr"}, err_addr, 0);
    chk({nm, "_ecnt"}, err_cnt, 0);
  endtask
  task automatic run(input vec_t v, input string nm);
    int lat = 0, wc = 0, nacc = 0;
    bit done = 0;
    tsel = v.to;
    mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb; mem_instr = v.instr;
    slv_rdata = {v.rd1, v.rd0};
    if (v.to) mem_valid_t = 1; else mem_valid_a = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      mem_valid_a = 0; mem_valid_t = 0; slv_ready_a = '0; slv_ready_t = '0;
      lat++;
      if (m_sv != 0) begin
        nacc++;
        chk({nm, "_sel"}, m_sv, v.sel);
        chk({nm, "_saddr"}, m_saddr, v.addr);
        chk({nm, "_swdata"}, m_swdata, v.wdata);
        chk({nm, "_swstrb"}, m_swstrb, v.wstrb);
        chk({nm, "_sinstr"}, m_sinstr, v.instr);
        if (wc == v.wt) begin
          if (v.to) slv_ready_t = m_sv; else slv_ready_a = m_sv;
        end
        wc++;
      end
      if (m_ready) begin
        done = 1;
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_rdata"}, m_rdata, v.rdata);
        chk({nm, "_err"}, m_err, v.err);
      end
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_nacc"}, nacc, v.nacc);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, m_ready, 0);
    chk({nm, "_ecnt"}, m_ecnt, v.ecnt);
    if (v.err) chk({nm, "_eaddr"}, m_eaddr, v.addr);
  endtask
  initial begin
    int n, m;
    vt[0] = '{0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 32'hAAAA_5555, 2'b01, 32'h1234_5678, 0, 2, 1, 16'd0};
    vt[1] = '{0, 32'h0001_0010, 32'hCAFE_F00D, 4'b0011, 0, 5, 32'h1111_1111, 32'h2222_2222, 2'b10, 32'h2222_2222, 0, 7, 6, 16'd0};
    vt[2] = '{0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 2, 0, 16'd1};
    vt[3] = '{0, 32'h0001_FFFC, 32'h0, 4'h0, 1, 2, 32'h3333_3333, 32'h0BAD_C0DE, 2'b10, 32'h0BAD_C0DE, 0, 4, 3, 16'd1};
    vt[4] = '{0, 32'h0002_0000, 32'h55AA_55AA, 4'hF, 0, 0, 32'h0, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 2, 0, 16'd2};
    vt[5] = '{0, 32'h0000_FFFF, 32'h0, 4'h0, 0, 1, 32'h5A5A_5A5A, 32'h7777_7777, 2'b01, 32'h5A5A_5A5A, 0, 3, 2, 16'd2};
    vt[6] = '{1, 32'h0000_0010, 32'h0, 4'h0, 0, 99, 32'h4444_4444, 32'h0, 2'b01, 32'hDEAD_BEEF, 1, 6, 4, 16'd1};
    vt[7] = '{1, 32'h0001_0020, 32'h0, 4'h0, 0, 3, 32'h0, 32'h6666_6666, 2'b10, 32'h6666_6666, 0, 5, 4, 16'd1};
    reset = 1; mem_valid_a = 0; mem_valid_t = 0; mem_instr = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; slv_ready_a = 0; slv_ready_t = 0; slv_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("rst");
    chk("rst_to", {mem_ready_t, slv_valid_t, bus_err_t, err_cnt_t}, 0);
    reset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) run(vt[i], $sformatf("v%0d", i));
    tsel = 0;
    mem_addr = 32'h0000_0008; mem_wstrb = 0; mem_instr = 0;
    slv_rdata = {32'h9999_9999, 32'h1357_9BDF};
    mem_valid_a = 1;
    @(posedge clk); #1;
    mem_valid_a = 0; slv_ready_a = 2'b10;
    n = 0;
    repeat (5) begin @(posedge clk); #1; n += int'(mem_ready); end
    chk("unsel_noready", n, 0);
    chk("unsel_valid", slv_valid, 2'b01);
    slv_ready_a = 2'b01;
    @(posedge clk); #1;
    slv_ready_a = 0;
    chk("unsel_ready", mem_ready, 1);
    chk("unsel_rdata", mem_rdata, 32'h1357_9BDF);
    @(posedge clk); #1;
    mem_valid_a = 1; slv_ready_a = 2'b11;
    n = 0; m = 0;
    repeat (8) begin @(posedge clk); #1; n += int'(mem_ready); m += int'(slv_valid != 0); end
    mem_valid_a = 0; slv_ready_a = 0;
    chk("hold_pulses", n, 3);
    chk("hold_access", m, 3);
    @(posedge clk); #1;
    mem_addr = 32'h0001_0040; mem_valid_a = 1;
    @(posedge clk); #1;
    mem_valid_a = 0;
    @(posedge clk); #1;
    chk("mid_access", slv_valid, 2'b10);
    #2 reset = 1;
    #1 chk_rst("mid_rst");
    @(posedge clk); #1;
    reset = 0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; n += int'(mem_ready); end
    chk("mid_noresp", n, 0);
    run(vt[0], "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
